pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage RV32I pipeline. It watches register indices and control bits in the IF/ID, ID/EX, EX/MEM and MEM/WB latches and drives hold, bubble and flush enables into those latches. It also produces EX-stage forwarding selects and sequences data-memory wait states. It sits beside the pipeline register bank and is the only source of its stall and flush controls.

## Interface
- DM_TIMEOUT, 16: maximum MEM_WAIT cycles before the error flag is raised.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- RS1_ID, RS2_ID  in  5  source indices of the instruction in ID.
- USE_RS1_ID, USE_RS2_ID  in  1  the ID instruction actually reads rs1/rs2.
- RS1_DE, RS2_DE  in  5  source indices of the instruction in EX.
- RD_DE, RD_EM, RD_MW  in  5  destination indices per stage.
- RegWrite_DE, RegWrite_EM, RegWrite_MW  in  1  write enables per stage.
- MemRead_DE  in  2  non-zero means the EX instruction is a load.
- BR_TAKEN_E  in  1  branch or jump resolved taken in EX.
- DM_REQ  in  1  MEM stage is accessing data memory.
- DM_ACK  in  1  data memory completes the access.
- STALL_F  out  1  hold PC.
- STALL_D  out  1  hold IF/ID.
- FLUSH_D  out  1  clear IF/ID to NOP.
- BUBBLE_E  out  1  load zeros into ID/EX control fields.
- FREEZE  out  1  hold every pipeline latch.
- FWD_A, FWD_B  out  2  EX operand select: 00 = RF_DATA_DE, 01 = ALU_VAL_EM, 10 = writeback value.
- DM_ERR  out  1  sticky timeout flag.
- STALL_CNT  out  CNT_W  saturating count of cycles with FREEZE or STALL_D asserted.

## Operation
- FSM states: RUN, MEM_WAIT.
  - RUN → MEM_WAIT when DM_REQ=1 and DM_ACK=0.
  - MEM_WAIT → RUN when DM_ACK=1, or when the wait counter reaches DM_TIMEOUT-1. The timeout case sets DM_ERR.
- Hazard rules:
  - Register index 0 never causes a hazard and is never forwarded.
  - A source matches a stage only if that stage's RegWrite is set and its RD equals the source.
- Load-use hazard: MemRead_DE≠0 and RD_DE matches a used ID source.
  - Response for one cycle: STALL_F=STALL_D=BUBBLE_E=1.
- Branch: BR_TAKEN_E=1 → FLUSH_D=1 and BUBBLE_E=1 in the same cycle. STALL_F=0 so the PC takes the target.
- Memory wait: FREEZE=1 combinationally whenever DM_REQ=1 and DM_ACK=0, in either state.
  - While FREEZE=1, all other stall, flush and bubble outputs are forced to 0.
- Priority: FREEZE > branch flush > load-use stall. A load-use stall coincident with a taken branch is dropped, because the ID instruction is squashed.
- A branch held in EX during a freeze is flushed in the first cycle after DM_ACK.
- Forwarding (EX sources): EM match → 01; otherwise MW match → 10; otherwise 00. EM takes precedence over MW for the same index.
- Counters:
  - Wait counter clears on entry to MEM_WAIT.
  - STALL_CNT saturates at all-ones.
  - DM_ERR clears only on reset.

## Timing
- Every control output is combinational from the current inputs and state, valid in the same cycle.
- A load-use stall costs exactly 1 bubble. A taken branch costs 2 squashed slots (IF/ID flush plus ID/EX bubble).
- Reset values: state RUN, all outputs 0, wait counter 0, STALL_CNT 0, DM_ERR 0.
- Asserting RST_N low mid-MEM_WAIT returns to RUN immediately with all outputs 0.
- Timeout: with DM_ACK held low, DM_ERR rises on the DM_TIMEOUT-th wait cycle. The FSM returns to RUN and FREEZE follows DM_REQ/DM_ACK thereafter.

## Configuration
- FORWARD_EN defined: forwarding and load-use logic as described above.
- FORWARD_EN undefined:
  - FWD_A/FWD_B are tied to 00.
  - Any used ID source matching DE or EM asserts STALL_F=STALL_D=BUBBLE_E=1, repeating each cycle until no match remains.
  - No MW check is needed, because the register file writes before it reads.
  - Branch, freeze and priority rules are unchanged.

## Structure
- Shared package:
  - FSM state encoding.
  - FWD select constants FWD_RF, FWD_EM, FWD_WB.
  - The NOP constant 32'h0000_0013.
- One sub-module, hazard_fwd_unit: purely combinational match, forwarding and stall-request logic. The top level holds the FSM, the counters and the priority resolution.

## Test plan
- `lw x5` in EX (MemRead_DE=2'b10, RD_DE=5) while ID reads x5 → one cycle of STALL_F=STALL_D=BUBBLE_E=1; next cycle FWD_A=10.
- `add x3` in EM and `add x3` in MW, EX reads x3 → FWD_A=01. With only MW matching → FWD_A=10. With rs1=x0 → FWD_A=00.
- BR_TAKEN_E=1 together with a load-use condition → FLUSH_D=1, BUBBLE_E=1, STALL_F=0.
- DM_REQ=1 with DM_ACK arriving after 3 cycles → FREEZE high for 3 cycles, STALL_CNT=3, state back to RUN.
- DM_REQ=1 with DM_ACK held 0 → DM_ERR=1 at cycle 16 and stays set until RST_N is pulsed low.
- Build without FORWARD_EN, `add x7` in DE, ID reads x7 → stalls 2 consecutive cycles, then proceeds; FWD_A stays 00.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
// Shared types and constants for the hazard/stall controller of the 5-stage
// RV32I pipeline: FSM state encoding, EX forwarding select codes, the NOP
// instruction word and the register-match helper used by every hazard check.
// Optional feature macro used by the block: FORWARD_EN.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file value from ID/EX
  localparam logic [1:0] FWD_EM = 2'b01;  // ALU result in EX/MEM
  localparam logic [1:0] FWD_WB = 2'b10;  // writeback value in MEM/WB

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

  // x0 is hard-wired, so it never matches a producer.
  function automatic logic src_match(input logic [4:0] src,
                                     input logic       we,
                                     input logic [4:0] rd);
    return (src != 5'd0) && we && (rd == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv
// hazard_fwd_unit
// Purely combinational register-match logic: EX-stage forwarding selects and
// the raw stall request for the ID instruction. Priority against branches and
// memory freezes is resolved by the parent.
// Macro: FORWARD_EN
//   defined   : EM/MW forwarding, stall only on load-use.
//   undefined : no forwarding, stall on any DE/EM producer match.
// Ports:
//   rs1_id_i/rs2_id_i, use_rs1_id_i/use_rs2_id_i : ID sources and read enables
//   rs1_de_i/rs2_de_i                            : EX sources
//   rd_*_i, regwrite_*_i                         : producers per stage
//   mem_read_de_i                                : non-zero = load in EX
//   fwd_a_o/fwd_b_o                              : EX operand selects
//   stall_req_o                                  : ID must wait
import pipeline_hazard_ctrl_pkg::*;

module hazard_fwd_unit (
  input  logic [4:0] rs1_id_i,
  input  logic [4:0] rs2_id_i,
  input  logic       use_rs1_id_i,
  input  logic       use_rs2_id_i,
  input  logic [4:0] rs1_de_i,
  input  logic [4:0] rs2_de_i,
  input  logic [4:0] rd_de_i,
  input  logic [4:0] rd_em_i,
  input  logic [4:0] rd_mw_i,
  input  logic       regwrite_de_i,
  input  logic       regwrite_em_i,
  input  logic       regwrite_mw_i,
  input  logic [1:0] mem_read_de_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       stall_req_o
);

  logic rs1_de_hit, rs2_de_hit;

  assign rs1_de_hit = use_rs1_id_i && src_match(rs1_id_i, regwrite_de_i, rd_de_i);
  assign rs2_de_hit = use_rs2_id_i && src_match(rs2_id_i, regwrite_de_i, rd_de_i);

`ifdef FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       we_em,
                                         input logic [4:0] rd_em,
                                         input logic       we_mw,
                                         input logic [4:0] rd_mw);
    // EM holds the younger write to the same register, so it wins.
    if (src_match(src, we_em, rd_em))      return FWD_EM;
    else if (src_match(src, we_mw, rd_mw)) return FWD_WB;
    else                                   return FWD_RF;
  endfunction

  assign fwd_a_o = fwd_sel(rs1_de_i, regwrite_em_i, rd_em_i, regwrite_mw_i, rd_mw_i);
  assign fwd_b_o = fwd_sel(rs2_de_i, regwrite_em_i, rd_em_i, regwrite_mw_i, rd_mw_i);

  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign stall_req_o = (mem_read_de_i != 2'b00) && (rs1_de_hit || rs2_de_hit);
`else
  logic rs1_em_hit, rs2_em_hit;
  logic unused_fwd_inputs;

  assign rs1_em_hit = use_rs1_id_i && src_match(rs1_id_i, regwrite_em_i, rd_em_i);
  assign rs2_em_hit = use_rs2_id_i && src_match(rs2_id_i, regwrite_em_i, rd_em_i);

  assign fwd_a_o = FWD_RF;
  assign fwd_b_o = FWD_RF;

  // The register file writes in the first half cycle, so MW never blocks ID.
  assign stall_req_o = rs1_de_hit || rs2_de_hit || rs1_em_hit || rs2_em_hit;

  assign unused_fwd_inputs = ^{rs1_de_i, rs2_de_i, rd_mw_i, regwrite_mw_i, mem_read_de_i};
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and stall controller for the 5-stage RV32I pipeline. Drives hold,
// bubble and flush enables for the pipeline latches, EX forwarding selects,
// and sequences data-memory wait states with a timeout error flag.
// Macro: FORWARD_EN (see hazard_fwd_unit).
// Parameters: DM_TIMEOUT (max wait cycles), CNT_W (stall counter width).
// Ports:
//   clk_i, rst_n_i                  : clock, async active-low reset
//   ID/EX/MEM/WB register indices, write enables, load flag (see sub-module)
//   br_taken_e_i                    : branch/jump taken in EX
//   dm_req_i, dm_ack_i              : data-memory handshake in MEM
//   stall_f_o, stall_d_o            : hold PC, hold IF/ID
//   flush_d_o, bubble_e_o           : squash IF/ID, zero ID/EX control
//   freeze_o                        : hold every latch
//   fwd_a_o, fwd_b_o                : EX operand selects
//   dm_err_o                        : sticky memory timeout flag
//   stall_cnt_o                     : saturating count of stalled cycles
import pipeline_hazard_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int unsigned DM_TIMEOUT = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       rs1_id_i,
  input  logic [4:0]       rs2_id_i,
  input  logic             use_rs1_id_i,
  input  logic             use_rs2_id_i,
  input  logic [4:0]       rs1_de_i,
  input  logic [4:0]       rs2_de_i,
  input  logic [4:0]       rd_de_i,
  input  logic [4:0]       rd_em_i,
  input  logic [4:0]       rd_mw_i,
  input  logic             regwrite_de_i,
  input  logic             regwrite_em_i,
  input  logic             regwrite_mw_i,
  input  logic [1:0]       mem_read_de_i,
  input  logic             br_taken_e_i,
  input  logic             dm_req_i,
  input  logic             dm_ack_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             flush_d_o,
  output logic             bubble_e_o,
  output logic             freeze_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             dm_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(DM_TIMEOUT + 1);
  // The RUN cycle that first sees the request is wait cycle 1 and the counter
  // is 0 in the first MEM_WAIT cycle, so the counter value in the
  // DM_TIMEOUT-th wait cycle is DM_TIMEOUT-2 (it would step to DM_TIMEOUT-1).
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DM_TIMEOUT - 2);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              dm_err_q, dm_err_d;

  logic       mem_stall, timeout_hit, stall_req;
  logic [1:0] fwd_a, fwd_b;

  hazard_fwd_unit u_hazard_fwd (
    .rs1_id_i      (rs1_id_i),
    .rs2_id_i      (rs2_id_i),
    .use_rs1_id_i  (use_rs1_id_i),
    .use_rs2_id_i  (use_rs2_id_i),
    .rs1_de_i      (rs1_de_i),
    .rs2_de_i      (rs2_de_i),
    .rd_de_i       (rd_de_i),
    .rd_em_i       (rd_em_i),
    .rd_mw_i       (rd_mw_i),
    .regwrite_de_i (regwrite_de_i),
    .regwrite_em_i (regwrite_em_i),
    .regwrite_mw_i (regwrite_mw_i),
    .mem_read_de_i (mem_read_de_i),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b),
    .stall_req_o   (stall_req)
  );

  assign mem_stall   = dm_req_i && !dm_ack_i;
  assign timeout_hit = (state_q == ST_MEM_WAIT) && !dm_ack_i && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (dm_ack_i || timeout_hit) state_d    = ST_RUN;
        else                         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are held low while reset is asserted even if the memory side is
  // still requesting, so the pipeline sees a clean idle controller.
  always_comb begin
    stall_f_o  = 1'b0;
    stall_d_o  = 1'b0;
    flush_d_o  = 1'b0;
    bubble_e_o = 1'b0;
    freeze_o   = rst_n_i && mem_stall;
    fwd_a_o    = rst_n_i ? fwd_a : FWD_RF;
    fwd_b_o    = rst_n_i ? fwd_b : FWD_RF;
    if (rst_n_i && !mem_stall) begin
      if (br_taken_e_i) begin
        // ID instruction is squashed, so any load-use stall is moot.
        flush_d_o  = 1'b1;
        bubble_e_o = 1'b1;
      end else if (stall_req) begin
        stall_f_o  = 1'b1;
        stall_d_o  = 1'b1;
        bubble_e_o = 1'b1;
      end
    end
  end

  assign dm_err_d    = dm_err_q || timeout_hit;
  assign dm_err_o    = dm_err_q || (rst_n_i && timeout_hit);
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((freeze_o || stall_d_o) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      dm_err_q    <= dm_err_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed-vector bench for pipeline_hazard_ctrl. The stall counter is built
// 4 bits wide so saturation is reached within the timeout sequence.
// Expected control vectors are {stall_f, stall_d, flush_d, bubble_e, freeze}.
module tb_pipeline_hazard_ctrl;

`ifdef FORWARD_EN
  localparam bit FWD_MODE = 1'b1;
`else
  localparam bit FWD_MODE = 1'b0;
`endif
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  logic          clk, rst_n;
  logic [4:0]    rs1_id, rs2_id, rs1_de, rs2_de, rd_de, rd_em, rd_mw;
  logic          use_rs1, use_rs2, rw_de, rw_em, rw_mw, br_taken, dm_req, dm_ack;
  logic [1:0]    mem_read;
  logic          stall_f, stall_d, flush_d, bubble_e, freeze, dm_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;
  logic [4:0]    ctl;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  assign ctl = {stall_f, stall_d, flush_d, bubble_e, freeze};

  pipeline_hazard_ctrl #(.DM_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .rs1_id_i      (rs1_id),
    .rs2_id_i      (rs2_id),
    .use_rs1_id_i  (use_rs1),
    .use_rs2_id_i  (use_rs2),
    .rs1_de_i      (rs1_de),
    .rs2_de_i      (rs2_de),
    .rd_de_i       (rd_de),
    .rd_em_i       (rd_em),
    .rd_mw_i       (rd_mw),
    .regwrite_de_i (rw_de),
    .regwrite_em_i (rw_em),
    .regwrite_mw_i (rw_mw),
    .mem_read_de_i (mem_read),
    .br_taken_e_i  (br_taken),
    .dm_req_i      (dm_req),
    .dm_ack_i      (dm_ack),
    .stall_f_o     (stall_f),
    .stall_d_o     (stall_d),
    .flush_d_o     (flush_d),
    .bubble_e_o    (bubble_e),
    .freeze_o      (freeze),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b),
    .dm_err_o      (dm_err),
    .stall_cnt_o   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    rs1_id = 5'd0; rs2_id = 5'd0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    rs1_de = 5'd0; rs2_de = 5'd0; rd_de = 5'd0; rd_em = 5'd0; rd_mw = 5'd0;
    rw_de = 1'b0; rw_em = 1'b0; rw_mw = 1'b0; mem_read = 2'b00;
    br_taken = 1'b0; dm_req = 1'b0; dm_ack = 1'b0;
  endtask

  // Clock once; counted says whether this cycle should bump STALL_CNT.
  task automatic step(input bit counted);
    @(posedge clk);
    if (counted && exp_cnt < CNT_MAX) exp_cnt++;
    #1;
  endtask

  task automatic load_use_x5();
    set_idle();
    rs1_id = 5'd5; use_rs1 = 1'b1; mem_read = 2'b10; rd_de = 5'd5; rw_de = 1'b1;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    #2;
    check_eq("reset_ctl", 16'(ctl), 16'b00000);
    check_eq("reset_cnt", 16'(stall_cnt), 16'd0);
    check_eq("reset_err", 16'(dm_err), 16'd0);
    #10 rst_n = 1'b1;
    step(0);

    // lw x5 in EX, ID reads x5: one-cycle stall + bubble
    load_use_x5(); #1;
    check_eq("ld_use_rs1", 16'(ctl), 16'b11010);
    step(1);
    check_eq("ld_use_cnt", 16'(stall_cnt), 16'(exp_cnt));
    // lw now in WB, dependent instruction in EX
    set_idle(); rs1_de = 5'd5; rd_mw = 5'd5; rw_mw = 1'b1; #1;
    check_eq("ld_use_fwd", 16'(fwd_a), FWD_MODE ? 16'd2 : 16'd0);
    check_eq("ld_use_done", 16'(ctl), 16'b00000);
    step(0);

    load_use_x5(); use_rs1 = 1'b0; #1;
    check_eq("ld_use_unused_src", 16'(ctl), 16'b00000);
    step(0);
    load_use_x5(); rs1_id = 5'd0; use_rs2 = 1'b1; rs2_id = 5'd5; #1;
    check_eq("ld_use_rs2", 16'(ctl), 16'b11010);
    step(1);
    load_use_x5(); rs1_id = 5'd0; rd_de = 5'd0; #1;
    check_eq("ld_use_x0", 16'(ctl), 16'b00000);
    step(0);
    load_use_x5(); rw_de = 1'b0; #1;
    check_eq("ld_use_no_we", 16'(ctl), 16'b00000);
    step(0);

    // add x7 marching DE -> EM -> MW while ID reads x7
    set_idle(); rs1_id = 5'd7; use_rs1 = 1'b1; rd_de = 5'd7; rw_de = 1'b1; #1;
    check_eq("alu_de_match", 16'(ctl), FWD_MODE ? 16'b00000 : 16'b11010);
    step(!FWD_MODE);
    set_idle(); rs1_id = 5'd7; use_rs1 = 1'b1; rd_em = 5'd7; rw_em = 1'b1; #1;
    check_eq("alu_em_match", 16'(ctl), FWD_MODE ? 16'b00000 : 16'b11010);
    step(!FWD_MODE);
    set_idle(); rs1_id = 5'd7; use_rs1 = 1'b1; rd_mw = 5'd7; rw_mw = 1'b1; #1;
    check_eq("alu_mw_nostall", 16'(ctl), 16'b00000);
    check_eq("alu_fwd_a", 16'(fwd_a), 16'd0);
    step(0);
    check_eq("alu_cnt", 16'(stall_cnt), 16'(exp_cnt));

    // forwarding priority
    set_idle(); rs1_de = 5'd3; rd_em = 5'd3; rw_em = 1'b1; rd_mw = 5'd3; rw_mw = 1'b1; #1;
    check_eq("fwd_em_over_mw", 16'(fwd_a), FWD_MODE ? 16'd1 : 16'd0);
    step(0);
    set_idle(); rs1_de = 5'd3; rd_em = 5'd3; rw_em = 1'b0; rd_mw = 5'd3; rw_mw = 1'b1; #1;
    check_eq("fwd_mw_only", 16'(fwd_a), FWD_MODE ? 16'd2 : 16'd0);
    step(0);
    set_idle(); rs1_de = 5'd0; rd_em = 5'd0; rw_em = 1'b1; #1;
    check_eq("fwd_x0", 16'(fwd_a), 16'd0);
    step(0);
    set_idle(); rs2_de = 5'd4; rd_em = 5'd6; rw_em = 1'b1; rd_mw = 5'd4; rw_mw = 1'b1; #1;
    check_eq("fwd_b_mw", 16'(fwd_b), FWD_MODE ? 16'd2 : 16'd0);
    check_eq("fwd_a_none", 16'(fwd_a), 16'd0);
    step(0);

    // taken branch with coincident load-use: flush wins, PC not held
    load_use_x5(); br_taken = 1'b1; #1;
    check_eq("br_over_ld_use", 16'(ctl), 16'b00110);
    step(0);

    // memory wait of 3 cycles with a branch held in EX
    load_use_x5(); br_taken = 1'b1; dm_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check_eq($sformatf("freeze_c%0d", k), 16'(ctl), 16'b00001);
      step(1);
    end
    dm_ack = 1'b1; #1;
    check_eq("br_after_ack", 16'(ctl), 16'b00110);
    step(0);
    set_idle(); #1;
    check_eq("wait3_cnt", 16'(stall_cnt), 16'(exp_cnt));
    check_eq("wait3_idle", 16'(ctl), 16'b00000);
    step(0);

    // timeout: DM_ACK never arrives
    set_idle(); dm_req = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      #1;
      check_eq($sformatf("to_err_c%0d", k), 16'(dm_err), (k >= 16) ? 16'd1 : 16'd0);
      step(1);
    end
    dm_req = 1'b0; #1;
    check_eq("to_freeze_off", 16'(freeze), 16'd0);
    check_eq("to_err_sticky", 16'(dm_err), 16'd1);
    check_eq("cnt_saturated", 16'(stall_cnt), 16'(exp_cnt));
    step(0);

    // reset in the middle of a wait
    set_idle(); dm_req = 1'b1;
    step(1);
    step(1);
    rst_n = 1'b0; exp_cnt = 0; #1;
    check_eq("rst_mid_ctl", 16'(ctl), 16'b00000);
    check_eq("rst_mid_err", 16'(dm_err), 16'd0);
    check_eq("rst_mid_cnt", 16'(stall_cnt), 16'd0);
    step(0);
    rst_n = 1'b1; set_idle(); #1;
    check_eq("post_rst_ctl", 16'(ctl), 16'b00000);
    step(0);
    load_use_x5(); #1;
    check_eq("post_rst_ld_use", 16'(ctl), 16'b11010);
    step(1);
    set_idle(); #1;
    check_eq("post_rst_cnt", 16'(stall_cnt), 16'(exp_cnt));
    check_eq("post_rst_err", 16'(dm_err), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
